// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one prescaled countdown timer to NUM_REQ requesters.
// Each grant runs a one-shot delay of `duration` ticks, then pulses that requester's done line.
module timer_arbiter #(
   parameter int unsigned                      NUM_REQ        = 4,
   parameter int unsigned                      DUR_WIDTH      = 16,
   parameter int unsigned                      PRESCALE_WIDTH = 26,
   parameter logic [PRESCALE_WIDTH-1:0]        PRESCALE       = PRESCALE_WIDTH'(49999)
) (
   input  logic                             baseClock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*DUR_WIDTH-1:0]     duration,
   output logic [NUM_REQ-1:0]               grant,
   output logic [NUM_REQ-1:0]               done,
   output logic                             busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                    r_state;
   logic [PRESCALE_WIDTH-1:0] r_pre;
   logic [DUR_WIDTH-1:0]      r_rem;
   logic [IDX_W-1:0]          r_last;
   logic [IDX_W-1:0]          r_owner;

   logic                      w_found;
   logic [IDX_W-1:0]          w_winner;
   int                        w_idx;

   // First pending requester after the last-served one, wrapping around.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = 0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         w_idx = (int'(r_last) + k) % int'(NUM_REQ);
         if (!w_found && req[w_idx[IDX_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge baseClock) begin
      if (reset) begin
         r_state <= StIdle;
         grant   <= '0;
         done    <= '0;
         busy    <= 1'b0;
         r_pre   <= '0;
         r_rem   <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
         r_owner <= '0;
      end else begin
         done <= '0;
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  grant   <= ONE_HOT0 << w_winner;
                  busy    <= 1'b1;
                  r_rem   <= duration[int'(w_winner)*int'(DUR_WIDTH) +: DUR_WIDTH];
                  r_pre   <= '0;
                  r_owner <= w_winner;
                  r_last  <= w_winner;
                  r_state <= StRun;
               end
            end
            StRun: begin
               // A dropped request aborts even on the cycle the count would have expired.
               if (!req[r_owner]) begin
                  grant   <= '0;
                  busy    <= 1'b0;
                  r_state <= StIdle;
               end else if (r_rem == '0) begin
                  grant   <= '0;
                  done    <= ONE_HOT0 << r_owner;
                  r_state <= StDone;
               end else if (r_pre == PRESCALE) begin
                  r_pre <= '0;
                  r_rem <= r_rem - 1'b1;
               end else begin
                  r_pre <= r_pre + 1'b1;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               grant   <= '0;
               busy    <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios on PRESCALE=0 and PRESCALE=2 instances,
// plus randomized traffic on the PRESCALE=2 instance against a cycle-count reference model.
module tb_timer_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int P2 = 2;

   logic           clk;
   logic           rst0, rst2;
   logic [NR-1:0]  req0, req2;
   logic [NR*DW-1:0] dur0, dur2;
   logic [NR-1:0]  grant0, done0, grant2, done2;
   logic           busy0, busy2;

   int n_checks;
   int n_errs;

   timer_arbiter #(
      .NUM_REQ(NR), .DUR_WIDTH(DW), .PRESCALE_WIDTH(26), .PRESCALE(26'd0)
   ) u_dut0 (
      .baseClock(clk), .reset(rst0), .req(req0), .duration(dur0),
      .grant(grant0), .done(done0), .busy(busy0)
   );

   timer_arbiter #(
      .NUM_REQ(NR), .DUR_WIDTH(DW), .PRESCALE_WIDTH(26), .PRESCALE(26'd2)
   ) u_dut2 (
      .baseClock(clk), .reset(rst2), .req(req2), .duration(dur2),
      .grant(grant2), .done(done2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1;
      rst2 = 1'b1;
      step();
      step();
      n_checks += 6;
      if (grant0 !== '0) begin n_errs++; $display("FAIL reset_grant0 got=%b want=0000", grant0); end
      if (done0 !== '0) begin n_errs++; $display("FAIL reset_done0 got=%b want=0000", done0); end
      if (busy0 !== 1'b0) begin n_errs++; $display("FAIL reset_busy0 got=%b want=0", busy0); end
      if (grant2 !== '0) begin n_errs++; $display("FAIL reset_grant2 got=%b want=0000", grant2); end
      if (done2 !== '0) begin n_errs++; $display("FAIL reset_done2 got=%b want=0000", done2); end
      if (busy2 !== 1'b0) begin n_errs++; $display("FAIL reset_busy2 got=%b want=0", busy2); end
      rst0 = 1'b0;
      rst2 = 1'b0;
      step();
   endtask

   // PRESCALE=0, D=3: grant cycles 1-4, done cycle 5, busy cycles 1-5.
   task automatic test_single();
      logic [NR-1:0] eg, ed;
      logic          eb;
      req0 = 4'b0001;
      dur0[15:0] = 16'd3;
      for (int c = 1; c <= 6; c++) begin
         step();
         eg = (c <= 4) ? 4'b0001 : 4'b0000;
         ed = (c == 5) ? 4'b0001 : 4'b0000;
         eb = (c <= 5);
         n_checks += 3;
         if (grant0 !== eg) begin n_errs++; $display("FAIL single_grant c=%0d got=%b want=%b", c, grant0, eg); end
         if (done0 !== ed) begin n_errs++; $display("FAIL single_done c=%0d got=%b want=%b", c, done0, ed); end
         if (busy0 !== eb) begin n_errs++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy0, eb); end
         if (c == 5) req0 = 4'b0000;
      end
   endtask

   // PRESCALE=2, D=2: grant for 7 cycles, done at cycle 8; mid-run duration change ignored.
   task automatic test_prescale();
      logic [NR-1:0] eg, ed;
      req2 = 4'b0010;
      dur2[31:16] = 16'd2;
      for (int c = 1; c <= 9; c++) begin
         step();
         eg = (c <= 7) ? 4'b0010 : 4'b0000;
         ed = (c == 8) ? 4'b0010 : 4'b0000;
         n_checks += 3;
         if (grant2 !== eg) begin n_errs++; $display("FAIL prescale_grant c=%0d got=%b want=%b", c, grant2, eg); end
         if (done2 !== ed) begin n_errs++; $display("FAIL prescale_done c=%0d got=%b want=%b", c, done2, ed); end
         if (busy2 !== (c <= 8)) begin n_errs++; $display("FAIL prescale_busy c=%0d got=%b want=%b", c, busy2, (c <= 8)); end
         if (c == 3) dur2[31:16] = 16'd9;
         if (c == 8) req2 = 4'b0000;
      end
   endtask

   task automatic test_zero();
      logic [NR-1:0] eg, ed;
      req2 = 4'b0100;
      dur2[47:32] = 16'd0;
      for (int c = 1; c <= 3; c++) begin
         step();
         eg = (c == 1) ? 4'b0100 : 4'b0000;
         ed = (c == 2) ? 4'b0100 : 4'b0000;
         n_checks += 2;
         if (grant2 !== eg) begin n_errs++; $display("FAIL zero_grant c=%0d got=%b want=%b", c, grant2, eg); end
         if (done2 !== ed) begin n_errs++; $display("FAIL zero_done c=%0d got=%b want=%b", c, done2, ed); end
         if (c == 2) req2 = 4'b0000;
      end
   endtask

   task automatic test_round_robin();
      int            order[5];
      int            n;
      logic [NR-1:0] prev;
      rst0 = 1'b1;
      step();
      rst0 = 1'b0;
      req0 = 4'b1111;
      dur0 = {16'd1, 16'd1, 16'd1, 16'd1};
      n = 0;
      prev = '0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         step();
         if (grant0 != '0 && prev == '0) begin
            for (int b = 0; b < NR; b++) if (grant0[b]) order[n] = b;
            n++;
         end
         prev = grant0;
      end
      n_checks++;
      if (n !== 5) begin n_errs++; $display("FAIL rr_grant_count got=%0d want=5", n); end
      for (int k = 0; k < n; k++) begin
         n_checks++;
         if (order[k] !== k % NR) begin
            n_errs++;
            $display("FAIL rr_order k=%0d got=%0d want=%0d", k, order[k], k % NR);
         end
      end
      req0 = 4'b0000;
      step();
      step();
      step();
   endtask

   task automatic test_abort();
      rst0 = 1'b1;
      step();
      rst0 = 1'b0;
      req0 = 4'b1000;
      dur0 = {16'd10, 16'd0, 16'd0, 16'd1};
      step();
      n_checks++;
      if (grant0 !== 4'b1000) begin n_errs++; $display("FAIL abort_grant3 got=%b want=1000", grant0); end
      req0 = 4'b1001;
      step();
      step();
      req0 = 4'b0001;
      step();
      n_checks += 3;
      if (grant0 !== 4'b0000) begin n_errs++; $display("FAIL abort_grant_fall got=%b want=0000", grant0); end
      if (done0 !== 4'b0000) begin n_errs++; $display("FAIL abort_no_done got=%b want=0000", done0); end
      if (busy0 !== 1'b0) begin n_errs++; $display("FAIL abort_idle_busy got=%b want=0", busy0); end
      step();
      n_checks += 2;
      if (grant0 !== 4'b0001) begin n_errs++; $display("FAIL abort_next_grant got=%b want=0001", grant0); end
      if (done0 !== 4'b0000) begin n_errs++; $display("FAIL abort_done_late got=%b want=0000", done0); end
      step();
      step();
      n_checks++;
      if (done0 !== 4'b0001) begin n_errs++; $display("FAIL abort_req0_done got=%b want=0001", done0); end
      req0 = 4'b0000;
      step();
   endtask

   task automatic test_reset_mid_run();
      rst0 = 1'b1;
      step();
      rst0 = 1'b0;
      req0 = 4'b0001;
      dur0 = {16'd0, 16'd0, 16'd0, 16'd50};
      step();
      step();
      n_checks++;
      if (grant0 !== 4'b0001) begin n_errs++; $display("FAIL midrst_pre_grant got=%b want=0001", grant0); end
      rst0 = 1'b1;
      step();
      n_checks += 3;
      if (grant0 !== 4'b0000) begin n_errs++; $display("FAIL midrst_grant got=%b want=0000", grant0); end
      if (done0 !== 4'b0000) begin n_errs++; $display("FAIL midrst_done got=%b want=0000", done0); end
      if (busy0 !== 1'b0) begin n_errs++; $display("FAIL midrst_busy got=%b want=0", busy0); end
      rst0 = 1'b0;
      req0 = 4'b1001;
      dur0 = '0;
      step();
      n_checks++;
      if (grant0 !== 4'b0001) begin n_errs++; $display("FAIL midrst_ptr_grant got=%b want=0001", grant0); end
      req0 = 4'b0000;
      step();
      step();
   endtask

   // Reference: a grant lasts D*(PRESCALE+1)+1 cycles unless the owner drops req first.
   task automatic test_random();
      int            m_state;  // 0 idle, 1 timing, 2 done pulse
      int            m_owner, m_left, m_last, w;
      logic [NR-1:0] m_done, eg, ed;
      logic          eb;
      rst2 = 1'b1;
      req2 = '0;
      step();
      rst2 = 1'b0;
      m_state = 0;
      m_owner = 0;
      m_left  = 0;
      m_last  = NR - 1;
      m_done  = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req2[i]) begin
               if ($urandom_range(3) == 0) begin
                  req2[i] = 1'b1;
                  dur2[i*DW +: DW] = DW'($urandom_range(3));
               end
            end else if (m_done[i]) begin
               if ($urandom_range(3) != 0) req2[i] = 1'b0;
            end else if ($urandom_range(49) == 0) begin
               req2[i] = 1'b0;
            end
            if ($urandom_range(3) == 0) dur2[i*DW +: DW] = DW'($urandom_range(3));
         end
         @(posedge clk);
         case (m_state)
            0: begin
               w = -1;
               for (int k = 1; k <= NR; k++)
                  if (w < 0 && req2[(m_last + k) % NR]) w = (m_last + k) % NR;
               if (w >= 0) begin
                  m_owner = w;
                  m_last  = w;
                  m_left  = int'(dur2[w*DW +: DW]) * (P2 + 1) + 1;
                  m_state = 1;
               end
            end
            1: begin
               if (!req2[m_owner]) m_state = 0;
               else if (m_left == 1) m_state = 2;
               else m_left--;
            end
            default: m_state = 0;
         endcase
         #1;
         eg = (m_state == 1) ? NR'(1) << m_owner : '0;
         ed = (m_state == 2) ? NR'(1) << m_owner : '0;
         eb = (m_state != 0);
         m_done = ed;
         n_checks += 3;
         if (grant2 !== eg) begin n_errs++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, grant2, eg); end
         if (done2 !== ed) begin n_errs++; $display("FAIL rand_done cyc=%0d got=%b want=%b", cyc, done2, ed); end
         if (busy2 !== eb) begin n_errs++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy2, eb); end
      end
      req2 = '0;
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rst0 = 1'b1;
      rst2 = 1'b1;
      req0 = '0;
      req2 = '0;
      dur0 = '0;
      dur2 = '0;
      test_reset();
      test_single();
      test_prescale();
      test_zero();
      test_round_robin();
      test_abort();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
